// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-operand forwarding select for the EX operand mux; youngest producer wins.
module fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic       rs_used,
    input  logic       ex_valid,
    input  logic       ex_we,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    input  logic       mem_valid,
    input  logic       mem_we,
    input  logic [4:0] mem_rd,
    input  logic       wb_valid,
    input  logic       wb_we,
    input  logic [4:0] wb_rd,
    output logic [1:0] sel
);

    logic rs_live;
    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // x0 is hard-wired zero, so a non-zero rs also guarantees rd != 0 on a match.
    assign rs_live = rs_used && (rs != REG_ZERO);
    // Load data is not ready in EX; the load-use stall covers that case.
    assign ex_hit  = rs_live && ex_valid && ex_we && !ex_is_load && (ex_rd == rs);
    assign mem_hit = rs_live && mem_valid && mem_we && (mem_rd == rs);
    assign wb_hit  = rs_live && wb_valid && wb_we && (wb_rd == rs);

    always_comb begin
        sel = FWD_RF;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: stalls, redirect flush, forwarding selects, perf counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_have_inst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs1_used,
    input  logic             id_rs2_used,
    input  logic             ex_valid,
    input  logic             ex_we,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             mem_valid,
    input  logic             mem_we,
    input  logic [4:0]       mem_rd,
    input  logic             wb_valid,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic             ex_redirect,
    input  logic             mem_busy,
    output logic             pc_stop,
    output logic             pipeline_stop,
    output logic             id_ex_bubble,
    output logic             control_hazard,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam int            FW      = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FC_ONE  = FW'(1);
    localparam logic [FW-1:0] RELOAD  = FW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    state_t        state;
    logic [FW-1:0] flush_cnt;
    logic          in_flush;
    logic          redirect_acc;
    logic          load_use;
    logic          load_stall;
    logic [1:0]    rs1_sel_raw;
    logic [1:0]    rs2_sel_raw;

    assign in_flush     = (state == FLUSH);
    assign redirect_acc = !rst && ex_redirect && !mem_busy;

    assign load_use = id_have_inst && ex_valid && ex_is_load && (ex_rd != REG_ZERO) &&
                      ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

    // The ID instruction is discarded under control_hazard, so its load-use is moot.
    assign control_hazard = !rst && (redirect_acc || in_flush);
    assign load_stall     = !rst && !mem_busy && !control_hazard && load_use;
    assign pc_stop        = !rst && (mem_busy || load_stall);
    assign pipeline_stop  = pc_stop;
    assign id_ex_bubble   = !rst && !mem_busy && (control_hazard || load_stall);

    fwd_sel u_fwd_rs1 (
        .rs(id_rs1), .rs_used(id_rs1_used),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .sel(rs1_sel_raw)
    );

    fwd_sel u_fwd_rs2 (
        .rs(id_rs2), .rs_used(id_rs2_used),
        .ex_valid(ex_valid), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_rd(mem_rd),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .sel(rs2_sel_raw)
    );

    assign fwd_rs1_sel = rst ? FWD_RF : rs1_sel_raw;
    assign fwd_rs2_sel = rst ? FWD_RF : rs2_sel_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= '0;
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pipeline_stop) begin
                stall_cycles <= sat_inc(stall_cycles);
            end
            if (redirect_acc) begin
                flush_events <= sat_inc(flush_events);
            end
            // Redirect (re)starts the flush window; mem_busy freezes it in place.
            if (redirect_acc) begin
                if (FLUSH_CYCLES > 1) begin
                    state     <= FLUSH;
                    flush_cnt <= RELOAD;
                end
            end else if (in_flush && !mem_busy) begin
                if (flush_cnt == FC_ONE) begin
                    state <= RUN;
                end else begin
                    flush_cnt <= flush_cnt - FC_ONE;
                end
            end
        end
    end

endmodule
